// File: rtl/mem_dma.sv
// Byte-wise memory-to-memory DMA: copies len bytes from src to dst (read/write pairs),
// or fills dst with a constant when built with MEM_DMA_FILL_EN defined.
module mem_dma (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       start,
   input  logic [7:0] src_addr,
   input  logic [7:0] dst_addr,
   input  logic [7:0] len,
   input  logic       fill,
   input  logic [7:0] fill_val,
   output logic       busy,
   output logic       done,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, FILL} state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] src_q, src_d;
   logic [7:0] dst_q, dst_d;
   logic [7:0] len_q, len_d;
   logic [7:0] buf_q, buf_d;
   logic       done_q, done_d;
   logic       last;

`ifdef MEM_DMA_FILL_EN
   logic [7:0] fill_val_q, fill_val_d;
`else
   logic       unused_fill;
   assign unused_fill = ^{fill, fill_val};
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         buf_q      <= '0;
         done_q     <= 1'b0;
`ifdef MEM_DMA_FILL_EN
         fill_val_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         buf_q      <= buf_d;
         done_q     <= done_d;
`ifdef MEM_DMA_FILL_EN
         fill_val_q <= fill_val_d;
`endif
      end
   end

   // len_q is never 0 outside IDLE, so len_q-1 cannot underflow while it matters.
   assign last = (cnt_q == len_q - 8'd1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      buf_d      = buf_q;
      done_d     = 1'b0;
`ifdef MEM_DMA_FILL_EN
      fill_val_d = fill_val_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               src_d      = src_addr;
               dst_d      = dst_addr;
               len_d      = len;
               cnt_d      = '0;
`ifdef MEM_DMA_FILL_EN
               fill_val_d = fill_val;
`endif
               if (len == 8'd0)
                  done_d = 1'b1;
`ifdef MEM_DMA_FILL_EN
               else if (fill)
                  state_d = FILL;
`endif
               else
                  state_d = RD;
            end
         end
         RD: begin
            buf_d   = mem_rdata;
            state_d = WR;
         end
         WR: begin
            if (last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d   = cnt_q + 8'd1;
               state_d = RD;
            end
         end
`ifdef MEM_DMA_FILL_EN
         FILL: begin
            if (last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Memory-side outputs decode only from registered state, so mem_we cannot glitch.
   always_comb begin
      busy      = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         RD: begin
            busy     = 1'b1;
            mem_addr = src_q + cnt_q;
         end
         WR: begin
            busy      = 1'b1;
            mem_addr  = dst_q + cnt_q;
            mem_wdata = buf_q;
            mem_we    = 1'b1;
         end
`ifdef MEM_DMA_FILL_EN
         FILL: begin
            busy      = 1'b1;
            mem_addr  = dst_q + cnt_q;
            mem_wdata = fill_val_q;
            mem_we    = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign done = done_q;

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: behavioural memory plus reference byte-array model and write scoreboard.
module tb_mem_dma;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       start;
   logic [7:0] src_addr, dst_addr, len, fill_val;
   logic       fill;
   logic       busy, done, mem_we;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];
   logic [15:0] exp_q [$];
   logic        tb_we;
   logic [7:0]  tb_addr, tb_data;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] cur_s, cur_d, cur_l;
   bit         cur_fill;

   mem_dma dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .fill(fill), .fill_val(fill_val), .busy(busy), .done(done),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 CLK = ~CLK;

   assign mem_rdata = mem[mem_addr];

   always @(posedge CLK) begin
      if (tb_we) mem[tb_addr] <= tb_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic mem_set(input logic [7:0] a, input logic [7:0] v);
      tb_we = 1'b1; tb_addr = a; tb_data = v;
      ref_mem[a] = v;
      @(negedge CLK);
      tb_we = 1'b0;
   endtask

   function automatic int mem_diff();
      int n = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   // Applies the transfer rules to the reference array and queues the expected writes.
   task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                         input bit f, input logic [7:0] v, input int nmodel);
      logic [7:0] a, val;
      bit fe;
`ifdef MEM_DMA_FILL_EN
      fe = f;
`else
      fe = 1'b0;
`endif
      cur_s = s; cur_d = d; cur_l = l; cur_fill = fe;
      for (int i = 0; i < nmodel; i++) begin
         a   = 8'(d + i);
         val = fe ? v : ref_mem[8'(s + i)];
         ref_mem[a] = val;
         exp_q.push_back({a, val});
      end
      start = 1'b1; src_addr = s; dst_addr = d; len = l; fill = f; fill_val = v;
      @(negedge CLK);
      start = 1'b0;
      src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom);
      fill = 1'($urandom); fill_val = 8'($urandom);
   endtask

   // Watches one transfer from the cycle after start up to and including the done cycle.
   task automatic monitor(input string tag, input bit poke);
      int busy_n = 0, we_n = 0, consec = 0, rd_n = 0, rd_bad = 0, wr_bad = 0;
      bit seen = 0, prev_we = 0;
      logic [15:0] e;
      for (int c = 0; c < 1000; c++) begin
         if (c > 0) @(negedge CLK);
         if (busy) busy_n++;
         if (mem_we) begin
            we_n++;
            if (prev_we) consec++;
            if (exp_q.size() == 0) wr_bad++;
            else begin
               e = exp_q.pop_front();
               if ({mem_addr, mem_wdata} !== e) wr_bad++;
            end
         end else if (busy) begin
            if (mem_addr !== 8'(cur_s + rd_n)) rd_bad++;
            rd_n++;
         end
         prev_we = mem_we;
         if (done) begin seen = 1; break; end
         if (poke && c == 2) begin
            start = 1'b1; src_addr = 8'($urandom); dst_addr = 8'($urandom);
            len = 8'($urandom_range(1, 255)); fill = 1'($urandom); fill_val = 8'($urandom);
         end
         if (poke && c == 3) start = 1'b0;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_cycles"}, busy_n, cur_fill ? 32'(cur_l) : 32'(cur_l) * 2);
      check({tag, "_we_cycles"}, we_n, 32'(cur_l));
      check({tag, "_we_back_to_back"}, consec, (cur_fill && cur_l > 0) ? 32'(cur_l) - 1 : 32'd0);
      check({tag, "_reads"}, rd_n, cur_fill ? 32'd0 : 32'(cur_l));
      check({tag, "_rd_addr_errs"}, rd_bad, 32'd0);
      check({tag, "_wr_errs"}, wr_bad, 32'd0);
      check({tag, "_wr_left"}, exp_q.size(), 32'd0);
      check({tag, "_mem_diff"}, mem_diff(), 32'd0);
      exp_q.delete();
   endtask

   task automatic idle_check(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if ({busy, done, mem_we, mem_addr, mem_wdata} !== 19'd0) bad++;
      end
      check({tag, "_idle"}, bad, 32'd0);
   endtask

   initial begin
      int wn;
      int dn;
      logic [7:0] s, d, l, v;
      bit f;
      // clock/reset
      RST_N = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
      fill = 1'b0; fill_val = '0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
      #1;
      check("reset_outputs", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 256; i++) mem_set(8'(i), 8'($urandom));
      check("reset_idle_after_release", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);

      // basic copy
      mem_set(8'h10, 8'hA1); mem_set(8'h11, 8'hA2); mem_set(8'h12, 8'hA3); mem_set(8'h13, 8'hA4);
      launch(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, 4);
      monitor("copy4", 1'b0);
      idle_check("copy4", 3);
      check("copy4_bytes", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'hA1A2A3A4);

      // zero length: done on the very next cycle, no busy, no writes
      launch(8'h55, 8'h66, 8'd0, 1'b0, 8'h00, 0);
      check("len0_done_next", {busy, done, mem_we}, 32'b010);
      monitor("len0", 1'b0);
      idle_check("len0", 3);

      // address wrap; 0x00 preloaded equal to 0xFE so forward copy matches the original bytes
      mem_set(8'hFE, 8'h5A); mem_set(8'hFF, 8'hC3); mem_set(8'h00, 8'h5A);
      launch(8'hFE, 8'h00, 8'd3, 1'b0, 8'h00, 3);
      monitor("wrap", 1'b0);
      check("wrap_bytes", {8'h00, mem[8'h00], mem[8'h01], mem[8'h02]}, 32'h005AC35A);

      // overlapping forward copy
      mem_set(8'h20, 8'h55); mem_set(8'h21, 8'h66);
      launch(8'h20, 8'h21, 8'd2, 1'b0, 8'h00, 2);
      monitor("overlap", 1'b0);
      check("overlap_bytes", {16'h0, mem[8'h21], mem[8'h22]}, 32'h5555);

      // fill request (becomes a copy when fill is compiled out)
      launch(8'h90, 8'h40, 8'd5, 1'b1, 8'h3C, 5);
      monitor("fill5", 1'b0);
`ifdef MEM_DMA_FILL_EN
      check("fill5_bytes", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h3C3C3C3C);
`endif

      // start while busy must be ignored
      launch(8'h05, 8'hC0, 8'd6, 1'b0, 8'h00, 6);
      monitor("poke", 1'b1);
      idle_check("poke", 2);

      // start in the done cycle is accepted
      launch(8'h60, 8'hD0, 8'd3, 1'b0, 8'h00, 3);
      monitor("chainA", 1'b0);
      launch(8'hD0, 8'hE0, 8'd2, 1'b0, 8'h00, 2);
      monitor("chainB", 1'b0);
      idle_check("chainB", 2);

      // reset after the third write of an 8-byte copy
      launch(8'h30, 8'hB0, 8'd8, 1'b0, 8'h00, 3);
      exp_q.delete();
      wn = 0;
      for (int c = 0; c < 40; c++) begin
         if (mem_we) wn++;
         if (wn == 3) break;
         @(negedge CLK);
      end
      check("rst_third_write", wn, 32'd3);
      @(posedge CLK);
      #2 RST_N = 1'b0;
      #1 check("rst_outputs_now", {busy, done, mem_we, mem_addr, mem_wdata}, 32'd0);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (done || busy || mem_we) dn++;
      end
      RST_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (done || busy || mem_we) dn++;
      end
      check("rst_no_activity", dn, 32'd0);
      check("rst_mem_diff", mem_diff(), 32'd0);

      // randomized transfers
      for (int t = 0; t < 20; t++) begin
         s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 16));
         f = 1'($urandom); v = 8'($urandom);
         launch(s, d, l, f, v, int'(l));
         monitor($sformatf("rnd%0d", t), (l >= 4) && 1'($urandom));
         if ($urandom_range(0, 1) == 0) idle_check($sformatf("rnd%0d", t), 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
